// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I opcodes, ALU codes and sequencer state type
package cpu_pkg;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
  localparam logic [2:0] INSTR_ADD   = 3'b000;
  localparam logic [2:0] INSTR_ADDI  = 3'b000;
  localparam logic [24:0] INSTR_ECALL = 25'd0;
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_PASSB = 4'hF;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} seq_state_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational classifier for the supported RV32I subset
module instr_decode
  import cpu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [24:0] upper,
  output logic        isLoad,
  output logic        isStore,
  output logic        isAddi,
  output logic        isAdd,
  output logic        isLui,
  output logic        isEcall,
  output logic        isIllegal
);
  always_comb begin
    isLoad    = opcode == OPCODE_LOAD;
    isStore   = opcode == OPCODE_STORE;
    isAddi    = opcode == OPCODE_OP_IMM && func3 == INSTR_ADDI;
    isAdd     = opcode == OPCODE_OP && func3 == INSTR_ADD;
    isLui     = opcode == OPCODE_LUI;
    isEcall   = opcode == OPCODE_SYSTEM && upper == INSTR_ECALL;
    isIllegal = !(isLoad || isStore || isAddi || isAdd || isLui || isEcall);
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with halt, trap and retire counter
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WORD-1:0] instr,
  input  logic            imemReady,
  input  logic            dmemReady,
  output logic            imemReq,
  output logic            irWrite,
  output logic            dmemReq,
  output logic            dmemWe,
  output logic            regWrite,
  output logic            pcWrite,
  output logic            aluSrcImm,
  output logic            wbSelMem,
  output logic [3:0]      ALUControl,
  output logic            halted,
  output logic            illegal,
  output logic [WORD-1:0] instret
);
  seq_state_t      r_state;
  logic [6:0]      r_opcode;
  logic [2:0]      r_func3;
  logic [24:0]     r_upper;
  logic [WORD-1:0] r_instret;
  logic w_load, w_store, w_addi, w_add, w_lui, w_ecall, w_illegal, w_alu_phase;
  instr_decode u_decode (
    .opcode(r_opcode), .func3(r_func3), .upper(r_upper),
    .isLoad(w_load), .isStore(w_store), .isAddi(w_addi), .isAdd(w_add),
    .isLui(w_lui), .isEcall(w_ecall), .isIllegal(w_illegal)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= FETCH;
      r_opcode  <= '0;
      r_func3   <= '0;
      r_upper   <= '0;
      r_instret <= '0;
    end else
      case (r_state)
        FETCH:
          if (imemReady) begin
            r_state  <= DECODE;
            r_opcode <= instr[6:0];
            r_func3  <= instr[14:12];
            r_upper  <= instr[31:7];
          end
        DECODE: r_state <= w_illegal ? TRAP : w_ecall ? HALT : EXEC;
        EXEC:   r_state <= (w_load || w_store) ? MEM : WB;
        MEM:
          if (dmemReady) begin
            r_state <= w_store ? FETCH : WB;
            if (w_store) r_instret <= r_instret + WORD'(1);
          end
        WB: begin
          r_state   <= FETCH;
          r_instret <= r_instret + WORD'(1);
        end
        default: r_state <= r_state;
      endcase
  // rst_n gating keeps the fetch side quiet while reset holds the FSM in FETCH
  assign w_alu_phase = r_state inside {DECODE, EXEC, MEM, WB};
  assign imemReq     = rst_n && r_state == FETCH;
  assign irWrite     = imemReq && imemReady;
  assign dmemReq     = r_state == MEM;
  assign dmemWe      = dmemReq && w_store;
  assign regWrite    = r_state == WB;
  assign wbSelMem    = regWrite && w_load;
  assign pcWrite     = regWrite || (dmemWe && dmemReady);
  assign aluSrcImm   = w_alu_phase && (w_load || w_store || w_addi || w_lui);
  assign ALUControl  = (w_alu_phase && w_lui) ? ALU_PASSB : ALU_ADD;
  assign halted      = r_state == HALT;
  assign illegal     = r_state == TRAP;
  assign instret     = r_instret;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed per-cycle strobe checks for the multicycle sequencer
module tb_multicycle_sequencer;
  localparam logic [13:0] IREQ = 14'h2000, IRW = 14'h1000, DREQ = 14'h0800, DWE = 14'h0400;
  localparam logic [13:0] RW = 14'h0200, PCW = 14'h0100, IMM = 14'h0080, WBM = 14'h0040;
  localparam logic [13:0] HLT = 14'h0020, ILL = 14'h0010, PB = 14'h000F;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        imemReady = 1'b0;
  logic        dmemReady = 1'b0;
  logic        imemReq, irWrite, dmemReq, dmemWe, regWrite, pcWrite, aluSrcImm, wbSelMem;
  logic        halted, illegal;
  logic [3:0]  ALUControl;
  logic [31:0] instret;
  logic [13:0] obs;
  int n_cmp = 0;
  int n_err = 0;
  multicycle_sequencer #(.WORD(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq), .irWrite(irWrite), .dmemReq(dmemReq), .dmemWe(dmemWe),
    .regWrite(regWrite), .pcWrite(pcWrite), .aluSrcImm(aluSrcImm), .wbSelMem(wbSelMem),
    .ALUControl(ALUControl), .halted(halted), .illegal(illegal), .instret(instret)
  );
  always #5 clk = ~clk;
  assign obs = {imemReq, irWrite, dmemReq, dmemWe, regWrite, pcWrite, aluSrcImm, wbSelMem,
                halted, illegal, ALUControl};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // called at a negedge: drive readies, check strobes, advance to the next negedge
  task automatic cyc(input string tag, input logic imr, input logic dmr, input logic [13:0] exp);
    imemReady = imr;
    dmemReady = dmr;
    #1;
    chk(tag, 32'(obs), 32'(exp));
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_strobes", 32'(obs), 32'h0);
    chk("reset_instret", instret, 32'h0);
    rst_n = 1'b1;
    instr = 32'h00500093;
    cyc("addi_fetch", 1, 0, IREQ | IRW);
    cyc("addi_decode", 0, 0, IMM);
    cyc("addi_exec", 0, 0, IMM);
    cyc("addi_wb", 0, 0, RW | PCW | IMM);
    chk("addi_instret", instret, 32'd1);
    instr = 32'h002081B3;
    cyc("add_f0", 0, 1, IREQ);
    cyc("add_f1", 0, 0, IREQ);
    cyc("add_f2", 0, 0, IREQ);
    cyc("add_f3", 1, 0, IREQ | IRW);
    cyc("add_decode", 0, 0, 14'h0);
    cyc("add_exec", 0, 0, 14'h0);
    cyc("add_wb", 0, 0, RW | PCW);
    chk("add_instret", instret, 32'd2);
    instr = 32'h0000A283;
    cyc("lw_fetch", 1, 0, IREQ | IRW);
    cyc("lw_decode", 0, 0, IMM);
    cyc("lw_exec", 0, 0, IMM);
    cyc("lw_m0", 1, 0, DREQ | IMM);
    cyc("lw_m1", 0, 0, DREQ | IMM);
    cyc("lw_m2", 0, 1, DREQ | IMM);
    cyc("lw_wb", 0, 0, RW | PCW | IMM | WBM);
    chk("lw_instret", instret, 32'd3);
    instr = 32'h0050A223;
    cyc("sw_fetch", 1, 0, IREQ | IRW);
    cyc("sw_decode", 0, 0, IMM);
    cyc("sw_exec", 0, 0, IMM);
    cyc("sw_mem", 0, 1, DREQ | DWE | IMM | PCW);
    chk("sw_instret", instret, 32'd4);
    instr = 32'h123450B7;
    cyc("lui_fetch", 1, 0, IREQ | IRW);
    cyc("lui_decode", 0, 0, IMM | PB);
    cyc("lui_exec", 0, 0, IMM | PB);
    cyc("lui_wb", 0, 0, RW | PCW | IMM | PB);
    chk("lui_instret", instret, 32'd5);
    instr = 32'h00500093;
    cyc("wrap_fetch", 1, 0, IREQ | IRW);
    force dut.r_instret = 32'hFFFF_FFFF;
    release dut.r_instret;
    #0 chk("wrap_preload", instret, 32'hFFFF_FFFF);
    cyc("wrap_decode", 0, 0, IMM);
    cyc("wrap_exec", 0, 0, IMM);
    cyc("wrap_wb", 0, 0, RW | PCW | IMM);
    chk("wrap_instret", instret, 32'h0);
    instr = 32'h0000A283;
    cyc("rst_fetch", 1, 0, IREQ | IRW);
    cyc("rst_decode", 0, 0, IMM);
    cyc("rst_exec", 0, 0, IMM);
    cyc("rst_m0", 0, 0, DREQ | IMM);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dmemreq", 32'(dmemReq), 32'h0);
    chk("rst_strobes", 32'(obs), 32'h0);
    chk("rst_instret", instret, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    instr = 32'h00000073;
    cyc("ecall_fetch", 1, 0, IREQ | IRW);
    cyc("ecall_decode", 0, 0, 14'h0);
    cyc("halt_0", 1, 0, HLT);
    cyc("halt_1", 1, 1, HLT);
    cyc("halt_2", 0, 0, HLT);
    chk("ecall_instret", instret, 32'h0);
    rst_n = 1'b0;
    #1 chk("halt_cleared", 32'(obs), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    instr = 32'h00000000;
    cyc("ill_fetch", 1, 0, IREQ | IRW);
    cyc("ill_decode", 0, 0, 14'h0);
    cyc("trap_0", 1, 0, ILL);
    cyc("trap_1", 0, 1, ILL);
    chk("ill_instret", instret, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
